// File: rtl/addsub_arb_pkg.sv
// Shared types and the round-robin search helper for addsub_rr_arbiter.
// Used in both builds of the block (ADDSUB_ARB_CMP_EN defined or not).
package addsub_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int unsigned MAX_REQ = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First asserted bit of req at or above ptr, wrapping at n (n <= MAX_REQ, ptr < n).
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [2:0]         ptr,
                                      input int unsigned        n);
        pick_t       r;
        int unsigned pos;
        r = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= n) pos = pos - n;
            if (k < n && !r.found && req[pos[2:0]]) begin
                r.found = 1'b1;
                r.idx   = pos[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub4.sv
// Existing 4-bit adder/subtractor: sub=1 computes a + ~b + 1.
module addsub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    output logic [3:0] result,
    output logic       cout
);

    logic [3:0] b_eff;
    logic [4:0] sum;

    always_comb begin
        b_eff  = sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {4'b0000, sub};
        result = sum[3:0];
        cout   = sum[4];
    end

endmodule

// File: rtl/addsub_rr_arbiter_rr_grant.sv
// Combinational round-robin picker: one-hot grant and encoded index of the winner.
module rr_grant
    import addsub_arb_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic [MAX_REQ-1:0] req_ext;
    pick_t              pick;

    always_comb begin
        req_ext           = '0;
        req_ext[NREQ-1:0] = req;
        pick              = rr_pick(req_ext, 3'(ptr), NREQ);
        idx               = pick.idx[IDW-1:0];
        grant             = '0;
        if (pick.found) grant[pick.idx[IDW-1:0]] = 1'b1;
    end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath among NREQ requesters.
// Define ADDSUB_ARB_CMP_EN to add registered rsp_eq/rsp_lt/rsp_gt outputs.
module addsub_rr_arbiter
    import addsub_arb_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_mode,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_cout
`ifdef ADDSUB_ARB_CMP_EN
    ,
    output logic                  rsp_eq,
    output logic                  rsp_lt,
    output logic                  rsp_gt
`endif
);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   op_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_mode;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   ptr_next;
    logic [WIDTH-1:0] dp_result;
    logic             dp_cout;

    rr_grant #(.NREQ(NREQ)) u_rr_grant (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    // Grant only in IDLE and never while reset is held.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && rst_n) req_ready = grant;
    end

    always_comb begin
        ptr_next = win_idx + 1'b1;
        if (win_idx == IDW'(NREQ - 1)) ptr_next = '0;
    end

    generate
        if (WIDTH == 4) begin : g_dp4
            addsub4 u_addsub4 (
                .a      (op_a),
                .b      (op_b),
                .sub    (op_mode),
                .result (dp_result),
                .cout   (dp_cout)
            );
        end else begin : g_dp_inline
            localparam int unsigned SW = WIDTH + 1;
            logic [WIDTH:0] sum;
            always_comb begin
                sum       = {1'b0, op_a} + {1'b0, (op_mode == MODE_SUB) ? ~op_b : op_b} + SW'(op_mode);
                dp_result = sum[WIDTH-1:0];
                dp_cout   = sum[WIDTH];
            end
        end
    endgenerate

`ifdef ADDSUB_ARB_CMP_EN
    logic cmp_eq, cmp_lt, cmp_gt;
    always_comb begin
        cmp_eq = (op_a == op_b);
        cmp_lt = (op_a <  op_b);
        cmp_gt = (op_a >  op_b);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            op_id      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_mode    <= MODE_ADD;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
`ifdef ADDSUB_ARB_CMP_EN
            rsp_eq     <= 1'b0;
            rsp_lt     <= 1'b0;
            rsp_gt     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        op_a    <= req_a[32'(win_idx) * WIDTH +: WIDTH];
                        op_b    <= req_b[32'(win_idx) * WIDTH +: WIDTH];
                        op_mode <= req_mode[win_idx];
                        op_id   <= win_idx;
                        rr_ptr  <= ptr_next;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= dp_result;
                    rsp_cout   <= dp_cout;
                    rsp_id     <= op_id;
                    rsp_valid  <= 1'b1;
`ifdef ADDSUB_ARB_CMP_EN
                    rsp_eq     <= cmp_eq;
                    rsp_lt     <= cmp_lt;
                    rsp_gt     <= cmp_gt;
`endif
                    state      <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
